// File: rtl/cdb_arbiter.sv
// cdb_arbiter: merges ALU and memory results onto one common data bus.
// Optional same-cycle bypass of empty FIFOs via macro CDB_BYPASS_EN.
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif

module cdb_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int ROB_W      = `ROB_SIZE_WIDTH
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rdy_in,
  input  logic             need_flush_in,
  input  logic             alu_valid_in,
  input  logic [31:0]      alu_value_in,
  input  logic [ROB_W-1:0] alu_rob_id_in,
  output logic             alu_full_out,
  input  logic             mem_valid_in,
  input  logic [31:0]      mem_value_in,
  input  logic [ROB_W-1:0] mem_rob_id_in,
  output logic             mem_full_out,
  output logic             cdb_valid_out,
  output logic [31:0]      cdb_value_out,
  output logic [ROB_W-1:0] cdb_rob_id_out,
  output logic             cdb_src_out
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0]      value;
    logic [ROB_W-1:0] tag;
  } res_t;

  res_t          fifo_q [2][FIFO_DEPTH];
  logic [PW-1:0] rd_ptr [2];
  logic [PW-1:0] wr_ptr [2];
  logic [CW-1:0] cnt    [2];
  logic          last_grant;

  logic [1:0] in_vld;
  res_t       in_res [2];
  res_t       cdat   [2];
  logic [1:0] empty;
  logic [1:0] full;
  logic [1:0] cand;
  logic [1:0] pop;
  logic [1:0] push;
  logic [1:0] byp;
  logic       gnt;
  logic       gsel;

  assign alu_full_out = full[0];
  assign mem_full_out = full[1];

  // Per-source status and candidate selection
  always_comb begin
    in_vld    = {mem_valid_in, alu_valid_in};
    in_res[0] = '{value: alu_value_in, tag: alu_rob_id_in};
    in_res[1] = '{value: mem_value_in, tag: mem_rob_id_in};
    empty     = '0;
    full      = '0;
    cand      = '0;
    for (int s = 0; s < 2; s++) begin
      empty[s] = (cnt[s] == '0);
      full[s]  = (cnt[s] == FULL_CNT);
`ifdef CDB_BYPASS_EN
      cand[s] = !empty[s] || in_vld[s];
      cdat[s] = empty[s] ? in_res[s]
                         : fifo_q[s][rd_ptr[s]];
`else
      cand[s] = !empty[s];
      cdat[s] = fifo_q[s][rd_ptr[s]];
`endif
    end
  end

  // Round-robin grant; contention goes to the source not served last
  always_comb begin
    gnt  = |cand;
    gsel = (&cand) ? ~last_grant : cand[1];
  end

  // Pop the granted head, push inputs that were not bypassed
  always_comb begin
    pop  = '0;
    push = '0;
    byp  = '0;
    for (int s = 0; s < 2; s++) begin
      pop[s]  = gnt && (gsel == 1'(s)) && !empty[s];
      byp[s]  = gnt && (gsel == 1'(s)) && empty[s];
      push[s] = in_vld[s] && !byp[s] && !full[s];
    end
  end

  // Pointers, counts, grant history and the broadcast register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int s = 0; s < 2; s++) begin
        rd_ptr[s] <= '0;
        wr_ptr[s] <= '0;
        cnt[s]    <= '0;
      end
      last_grant     <= 1'b1;
      cdb_valid_out  <= 1'b0;
      cdb_value_out  <= '0;
      cdb_rob_id_out <= '0;
      cdb_src_out    <= 1'b0;
    end else if (!rdy_in) begin
      cdb_valid_out <= 1'b0;
    end else if (need_flush_in) begin
      for (int s = 0; s < 2; s++) begin
        rd_ptr[s] <= '0;
        wr_ptr[s] <= '0;
        cnt[s]    <= '0;
      end
      last_grant    <= 1'b1;
      cdb_valid_out <= 1'b0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (pop[s])
          rd_ptr[s] <= rd_ptr[s] + PW'(1);
        if (push[s])
          wr_ptr[s] <= wr_ptr[s] + PW'(1);
        if (push[s] && !pop[s])
          cnt[s] <= cnt[s] + CW'(1);
        else if (pop[s] && !push[s])
          cnt[s] <= cnt[s] - CW'(1);
      end
      cdb_valid_out <= gnt;
      if (gnt) begin
        cdb_value_out  <= cdat[gsel].value;
        cdb_rob_id_out <= cdat[gsel].tag;
        cdb_src_out    <= gsel;
        last_grant     <= gsel;
      end
    end
  end

  // FIFO storage writes; contents need no reset
  always_ff @(posedge clk_in) begin
    if (rdy_in && !need_flush_in) begin
      for (int s = 0; s < 2; s++) begin
        if (push[s])
          fifo_q[s][wr_ptr[s]] <= in_res[s];
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed checks of the CDB arbiter.
// Expected latencies follow CDB_BYPASS_EN when defined.
module tb_cdb_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        need_flush_in;
  logic        alu_valid_in;
  logic [31:0] alu_value_in;
  logic [3:0]  alu_rob_id_in;
  logic        alu_full_out;
  logic        mem_valid_in;
  logic [31:0] mem_value_in;
  logic [3:0]  mem_rob_id_in;
  logic        mem_full_out;
  logic        cdb_valid_out;
  logic [31:0] cdb_value_out;
  logic [3:0]  cdb_rob_id_out;
  logic        cdb_src_out;

  int checks   = 0;
  int failures = 0;

  logic [31:0] q_val [$];
  logic [31:0] q_tag [$];
  logic [31:0] q_src [$];
  logic [31:0] expq  [$];
  int          acc;
  int          mem_out;
  logic        saw_drop;

  always #5 clk_in = ~clk_in;

  cdb_arbiter #(.FIFO_DEPTH(4), .ROB_W(4)) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .rdy_in         (rdy_in),
    .need_flush_in  (need_flush_in),
    .alu_valid_in   (alu_valid_in),
    .alu_value_in   (alu_value_in),
    .alu_rob_id_in  (alu_rob_id_in),
    .alu_full_out   (alu_full_out),
    .mem_valid_in   (mem_valid_in),
    .mem_value_in   (mem_value_in),
    .mem_rob_id_in  (mem_rob_id_in),
    .mem_full_out   (mem_full_out),
    .cdb_valid_out  (cdb_valid_out),
    .cdb_value_out  (cdb_value_out),
    .cdb_rob_id_out (cdb_rob_id_out),
    .cdb_src_out    (cdb_src_out)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    alu_valid_in  = 1'b0;
    alu_value_in  = '0;
    alu_rob_id_in = '0;
    mem_valid_in  = 1'b0;
    mem_value_in  = '0;
    mem_rob_id_in = '0;
    need_flush_in = 1'b0;
    rdy_in        = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    rst_n_in = 1'b0;
    tick();
    tick();
    rst_n_in = 1'b1;
    tick();
  endtask

  task automatic drive_alu(input logic [3:0] t,
                           input logic [31:0] v);
    alu_valid_in  = 1'b1;
    alu_rob_id_in = t;
    alu_value_in  = v;
  endtask

  task automatic drive_mem(input logic [3:0] t,
                           input logic [31:0] v);
    mem_valid_in  = 1'b1;
    mem_rob_id_in = t;
    mem_value_in  = v;
  endtask

  task automatic grab();
    if (cdb_valid_out) begin
      q_val.push_back(cdb_value_out);
      q_tag.push_back({28'd0, cdb_rob_id_out});
      q_src.push_back({31'd0, cdb_src_out});
    end
  endtask

  task automatic obs_mem();
    if (cdb_valid_out && cdb_src_out) begin
      mem_out++;
      if (cdb_rob_id_out == 4'd15)
        saw_drop = 1'b1;
      if (expq.size() > 0)
        chk("fill_order", {28'd0, cdb_rob_id_out},
            expq.pop_front());
      else
        chk("fill_extra", expq.size(), 1);
    end
    chk("fill_full", {31'd0, mem_full_out},
        {31'd0, expq.size() == 4});
  endtask

  initial begin
    int ai;
    int mi;
    int exp_acc;
    int c;
    logic [31:0] es;

    // reset state
    idle();
    rst_n_in = 1'b0;
    #2;
    chk("rst_valid", {31'd0, cdb_valid_out}, 0);
    chk("rst_value", cdb_value_out, 0);
    chk("rst_tag", {28'd0, cdb_rob_id_out}, 0);
    chk("rst_src", {31'd0, cdb_src_out}, 0);
    chk("rst_afull", {31'd0, alu_full_out}, 0);
    chk("rst_mfull", {31'd0, mem_full_out}, 0);
    do_reset();

    // single ALU result latency
    drive_alu(4'd3, 32'h11);
    tick();
    idle();
`ifdef CDB_BYPASS_EN
    chk("lat_k_valid", {31'd0, cdb_valid_out}, 1);
    chk("lat_k_value", cdb_value_out, 32'h11);
    chk("lat_k_tag", {28'd0, cdb_rob_id_out}, 3);
    chk("lat_k_src", {31'd0, cdb_src_out}, 0);
    tick();
    chk("lat_k1_valid", {31'd0, cdb_valid_out}, 0);
`else
    chk("lat_k_valid", {31'd0, cdb_valid_out}, 0);
    tick();
    chk("lat_k1_valid", {31'd0, cdb_valid_out}, 1);
    chk("lat_k1_value", cdb_value_out, 32'h11);
    chk("lat_k1_tag", {28'd0, cdb_rob_id_out}, 3);
    chk("lat_k1_src", {31'd0, cdb_src_out}, 0);
`endif

    // continuous contention: strict alternation, ALU first
    do_reset();
    q_val.delete(); q_tag.delete(); q_src.delete();
    for (int i = 0; i < 30; i++) begin
      idle();
      if (i < 6) begin
        drive_alu(4'(i + 1), 32'hA00 + i);
        drive_mem(4'(i + 8), 32'hB00 + i);
      end
      tick();
      grab();
    end
    idle();
    chk("ct_count", q_val.size(), 12);
    ai = 0;
    mi = 0;
    for (int i = 0; i < q_val.size() && i < 12; i++) begin
      es = i % 2;
      chk("ct_src", q_src[i], es);
      if (es == 0) begin
        chk("ct_alu_val", q_val[i], 32'hA00 + ai);
        chk("ct_alu_tag", q_tag[i], ai + 1);
        ai++;
      end else begin
        chk("ct_mem_val", q_val[i], 32'hB00 + mi);
        chk("ct_mem_tag", q_tag[i], mi + 8);
        mi++;
      end
    end

    // fill memory FIFO under contention, drop push while full
    do_reset();
    expq.delete();
    acc = 0;
    mem_out = 0;
    saw_drop = 1'b0;
    c = 0;
    while (!mem_full_out && c < 20) begin
      idle();
      alu_valid_in = !alu_full_out;
      drive_mem(4'(acc + 1), 32'hC00 + acc);
      expq.push_back(acc + 1);
      acc++;
      tick();
      obs_mem();
      c++;
    end
`ifdef CDB_BYPASS_EN
    exp_acc = 7;
`else
    exp_acc = 6;
`endif
    chk("fill_seen", {31'd0, mem_full_out}, 1);
    chk("fill_pushes", acc, exp_acc);
    idle();
    drive_mem(4'd15, 32'hDEAD);
    tick();
    obs_mem();
    idle();
    for (int i = 0; i < 12; i++) begin
      tick();
      obs_mem();
    end
    chk("fill_drained", expq.size(), 0);
    chk("fill_total", mem_out, acc);
    chk("fill_drop", {31'd0, saw_drop}, 0);

    // flush discards buffered and same-cycle results
    do_reset();
    drive_alu(4'd1, 32'h61);
    drive_mem(4'd2, 32'h62);
    tick();
    idle();
    drive_alu(4'd7, 32'h77);
    need_flush_in = 1'b1;
    tick();
    idle();
    chk("fl_valid", {31'd0, cdb_valid_out}, 0);
    saw_drop = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (cdb_valid_out)
        saw_drop = 1'b1;
    end
    chk("fl_quiet", {31'd0, saw_drop}, 0);
    chk("fl_afull", {31'd0, alu_full_out}, 0);
    drive_alu(4'd4, 32'h44);
    tick();
    idle();
    q_val.delete(); q_tag.delete(); q_src.delete();
    grab();
    for (int i = 0; i < 4; i++) begin
      tick();
      grab();
    end
    chk("fl_after_cnt", q_tag.size(), 1);
    if (q_tag.size() > 0)
      chk("fl_after_tag", q_tag[0], 4);

    // freeze with rdy_in low
    do_reset();
    drive_alu(4'd1, 32'h51);
    drive_mem(4'd2, 32'h52);
    tick();
    idle();
`ifdef CDB_BYPASS_EN
    chk("frz_pre", {31'd0, cdb_valid_out}, 1);
    chk("frz_pre_tag", {28'd0, cdb_rob_id_out}, 1);
`else
    chk("frz_pre", {31'd0, cdb_valid_out}, 0);
`endif
    rdy_in = 1'b0;
    drive_alu(4'd9, 32'h99);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_valid", {31'd0, cdb_valid_out}, 0);
    end
    idle();
    q_val.delete(); q_tag.delete(); q_src.delete();
    for (int i = 0; i < 6; i++) begin
      tick();
      grab();
    end
`ifdef CDB_BYPASS_EN
    chk("frz_cnt", q_tag.size(), 1);
    if (q_tag.size() > 0) begin
      chk("frz_tag0", q_tag[0], 2);
      chk("frz_src0", q_src[0], 1);
    end
`else
    chk("frz_cnt", q_tag.size(), 2);
    if (q_tag.size() > 1) begin
      chk("frz_tag0", q_tag[0], 1);
      chk("frz_src0", q_src[0], 0);
      chk("frz_tag1", q_tag[1], 2);
      chk("frz_src1", q_src[1], 1);
    end
`endif

    // async reset mid-drain
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_alu(4'(i + 1), 32'h100 + i);
      drive_mem(4'(i + 8), 32'h200 + i);
      tick();
    end
    idle();
    chk("ar_pre_valid", {31'd0, cdb_valid_out}, 1);
    #2;
    rst_n_in = 1'b0;
    #1;
    chk("ar_valid", {31'd0, cdb_valid_out}, 0);
    chk("ar_value", cdb_value_out, 0);
    chk("ar_tag", {28'd0, cdb_rob_id_out}, 0);
    chk("ar_src", {31'd0, cdb_src_out}, 0);
    chk("ar_mfull", {31'd0, mem_full_out}, 0);
    #3;
    rst_n_in = 1'b1;
    tick();
    drive_alu(4'd5, 32'h55);
    drive_mem(4'd6, 32'h66);
    tick();
    idle();
    c = 0;
    while (!cdb_valid_out && c < 5) begin
      tick();
      c++;
    end
    chk("ar_first_valid", {31'd0, cdb_valid_out}, 1);
    chk("ar_first_src", {31'd0, cdb_src_out}, 0);
    chk("ar_first_tag", {28'd0, cdb_rob_id_out}, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
